// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - opcodes, state encoding and control codes for the multicycle controller
package multicycle_control_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, so it is valid in every state.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller <-> datapath signal bundle
interface multicycle_control_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [2:0] alu_control;
  logic       illegal_op;
  logic       instr_done;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, illegal_op, instr_done
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
           alu_src_b, imm_src, reg_write, alu_control, illegal_op, instr_done
  );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - ALUOp/funct to alu_control decode
module alu_decoder
  import multicycle_control_pkg::*;
(
  input  aluop_t     alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  // sub only for R-type with funct7b5; I-type addi with imm[10] set stays add
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the RV32I multicycle datapath
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int unsigned MEM_LAT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  aluop_t     alu_op;
  logic       mem_final;
  logic       pc_w, adr, mem_w, ir_w, reg_w, ill, done;
  logic [1:0] res_src, src_a, src_b;

  assign mem_final = (cnt == LAT);

  // State and wait counter; reset abandons any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state and per-state control; memory states hold until the counter reaches MEM_LAT.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    pc_w      = 1'b0;
    adr       = 1'b0;
    mem_w     = 1'b0;
    ir_w      = 1'b0;
    reg_w     = 1'b0;
    ill       = 1'b0;
    done      = 1'b0;
    res_src   = 2'b00;
    src_a     = 2'b00;
    src_b     = 2'b00;
    alu_op    = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        src_b   = 2'b10;
        res_src = 2'b10;
        if (mem_final) begin
          ir_w      = 1'b1;
          pc_w      = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            ill       = 1'b1;
            done      = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a     = 2'b10;
        src_b     = 2'b01;
        state_nxt = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr = 1'b1;
        if (mem_final) state_nxt = S_MEMWB;
        else           cnt_nxt   = cnt + 4'd1;
      end
      S_MEMWB: begin
        res_src   = 2'b01;
        reg_w     = 1'b1;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_MEMWRITE: begin
        adr   = 1'b1;
        mem_w = 1'b1;
        if (mem_final) begin
          done      = 1'b1;
          state_nxt = S_FETCH;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      S_EXECR: begin
        src_a     = 2'b10;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_EXECI: begin
        src_a     = 2'b10;
        src_b     = 2'b01;
        alu_op    = ALUOP_FUNCT;
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w     = 1'b1;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_BEQ: begin
        src_a     = 2'b10;
        alu_op    = ALUOP_SUB;
        pc_w      = bus.zero;
        done      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_JAL: begin
        src_a     = 2'b01;
        src_b     = 2'b10;
        pc_w      = 1'b1;
        state_nxt = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  alu_decoder u_alu_dec (
    .alu_op      (alu_op),
    .funct3      (bus.funct3),
    .funct7b5    (bus.funct7b5),
    .op5         (bus.op[5]),
    .alu_control (bus.alu_control)
  );

  // Enables are gated by rst_n so nothing writes while reset is held.
  assign bus.pc_write   = pc_w  & rst_n;
  assign bus.ir_write   = ir_w  & rst_n;
  assign bus.mem_write  = mem_w & rst_n;
  assign bus.reg_write  = reg_w & rst_n;
  assign bus.illegal_op = ill   & rst_n;
  assign bus.instr_done = done  & rst_n;
  assign bus.adr_src    = adr;
  assign bus.result_src = res_src;
  assign bus.alu_src_a  = src_a;
  assign bus.alu_src_b  = src_b;
  assign bus.imm_src    = imm_src_of(bus.op);

endmodule
